// File: rtl/bert_sequencer.sv
// BERT run sequencer: clears the checker, waits for lock with a timeout, then
// counts received words and error bits over a configured window.
module bert_sequencer #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned TO_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             sel_cfg,
  input  logic [CNT_W-1:0] win_len,
  input  logic [TO_W-1:0]  sync_to,
  input  logic             lock,
  input  logic             err_valid,
  input  logic [7:0]       err_word,
  output logic             sel,
  output logic             gen_en,
  output logic             chk_clr,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] err_total,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_SYNC    = 3'd2,
    S_MEASURE = 3'd3,
    S_DONE    = 3'd4,
    S_FAIL    = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TO_W:0]    TO_ONE  = (TO_W+1)'(1);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [TO_W-1:0]  to_lim_q, to_lim_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] err_tot_q, err_tot_d;
  logic             gen_en_q, chk_clr_q, busy_q, done_q, fail_q;
  logic             gen_en_d, chk_clr_d, busy_d, done_d, fail_d;

  logic [3:0]       pop;
  logic [CNT_W:0]   err_sum;
  logic [CNT_W-1:0] err_sat;
  logic [CNT_W-1:0] word_inc;
  logic [TO_W:0]    to_inc;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      pop = pop + {3'b000, err_word[i]};
    end
  end

  // One extra bit catches the carry so the total clamps instead of wrapping.
  assign err_sum  = {1'b0, err_tot_q} + {{(CNT_W-3){1'b0}}, pop};
  assign err_sat  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
  assign word_inc = word_cnt_q + CNT_ONE;
  assign to_inc   = {1'b0, to_cnt_q} + TO_ONE;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    win_d      = win_q;
    to_lim_d   = to_lim_q;
    to_cnt_d   = to_cnt_q;
    word_cnt_d = word_cnt_q;
    err_tot_d  = err_tot_q;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start && !abort) begin
          sel_d      = sel_cfg;
          win_d      = win_len;
          to_lim_d   = sync_to;
          word_cnt_d = '0;
          err_tot_d  = '0;
          state_d    = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          to_cnt_d = '0;
          state_d  = S_SYNC;
        end
      end
      S_SYNC: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (lock) begin
          state_d = (win_q == '0) ? S_DONE : S_MEASURE;
        end else if (to_inc >= {1'b0, to_lim_q}) begin
          // Fires on the increment that reaches the limit; a zero limit fails after one cycle.
          state_d = S_FAIL;
        end else begin
          to_cnt_d = to_inc[TO_W-1:0];
        end
      end
      S_MEASURE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!lock) begin
          state_d = S_FAIL;
        end else if (err_valid) begin
          word_cnt_d = word_inc;
          err_tot_d  = err_sat;
          if (word_inc == win_q) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Flag outputs are decoded from the next state so they are registered
  // and line up with the state register.
  always_comb begin
    gen_en_d  = (state_d == S_SYNC) || (state_d == S_MEASURE);
    chk_clr_d = (state_d == S_CLEAR);
    busy_d    = (state_d == S_CLEAR) || (state_d == S_SYNC) || (state_d == S_MEASURE);
    done_d    = (state_d == S_DONE);
    fail_d    = (state_d == S_FAIL);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sel_q      <= 1'b0;
      win_q      <= '0;
      to_lim_q   <= '0;
      to_cnt_q   <= '0;
      word_cnt_q <= '0;
      err_tot_q  <= '0;
      gen_en_q   <= 1'b0;
      chk_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      win_q      <= win_d;
      to_lim_q   <= to_lim_d;
      to_cnt_q   <= to_cnt_d;
      word_cnt_q <= word_cnt_d;
      err_tot_q  <= err_tot_d;
      gen_en_q   <= gen_en_d;
      chk_clr_q  <= chk_clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
    end
  end

  assign state      = state_q;
  assign sel        = sel_q;
  assign gen_en     = gen_en_q;
  assign chk_clr    = chk_clr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign word_count = word_cnt_q;
  assign err_total  = err_tot_q;

endmodule

// File: doc/bert_sequencer.md
BERT_SEQUENCER -- requirements
Module: bert_sequencer

Interface
REQ-001 Parameter CNT_W, default 32: width of the word counter, the error total and the window length.
REQ-002 Parameter TO_W, default 16: width of the sync timeout.
REQ-003 Port clock, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: single-cycle request to begin a test run.
REQ-006 Port abort, input, 1: single-cycle request to cancel the current run.
REQ-007 Port sel_cfg, input, 1: pattern select for the run.
REQ-008 Port win_len, input, CNT_W: number of words to measure.
REQ-009 Port sync_to, input, TO_W: maximum number of SYNC cycles allowed before lock.
REQ-010 Port lock, input, 1: the checker is aligned to the received pattern.
REQ-011 Port err_valid, input, 1: err_word is valid this cycle.
REQ-012 Port err_word, input, 8: bitwise error mask for one received word.
REQ-013 Port sel, output, 1: pattern select driven to the generator and checker.
REQ-014 Port gen_en, output, 1: enables the pattern generator.
REQ-015 Port chk_clr, output, 1: clears the checker.
REQ-016 Port busy, output, 1: a run is in progress.
REQ-017 Port done, output, 1: the run completed.
REQ-018 Port fail, output, 1: the run failed because of sync timeout or lock loss.
REQ-019 Port word_count, output, CNT_W: number of words measured.
REQ-020 Port err_total, output, CNT_W: accumulated error bits.
REQ-021 Port state, output, 3: encoding of the current state.

Function
REQ-022 The state machine SHALL have the states IDLE=0, CLEAR=1, SYNC=2, MEASURE=3, DONE=4 and FAIL=5; all outputs SHALL be registered.
REQ-023 In IDLE, DONE or FAIL, start with abort=0 SHALL latch sel_cfg, win_len and sync_to into configuration registers, zero word_count and err_total, and go to CLEAR.
REQ-024 start SHALL be ignored in CLEAR, SYNC and MEASURE.
REQ-025 CLEAR SHALL last exactly 1 cycle with chk_clr=1 and gen_en=0, and then go to SYNC.
REQ-026 In SYNC and MEASURE, gen_en=1; sel SHALL equal the latched sel_cfg from CLEAR until the next start.
REQ-027 SYNC SHALL use a timeout counter that starts at 0 on SYNC entry and increments each cycle that lock=0.
- lock=1 → MEASURE.
- Counter reaches the latched sync_to while lock=0 → FAIL.
- sync_to=0 → FAIL after 1 SYNC cycle unless lock=1 in that cycle.
REQ-028 In MEASURE, each cycle with err_valid=1 SHALL increment word_count by 1 and add the popcount of err_word (0..8) to err_total.
REQ-029 err_total SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-030 When word_count reaches the latched win_len (the update that makes word_count equal win_len), the state SHALL become DONE on the next edge, and no further words are counted.
REQ-031 A latched win_len of 0 SHALL cause SYNC→DONE on lock with word_count=0.
REQ-032 lock=0 in any MEASURE cycle SHALL cause →FAIL on the next edge, and that cycle's word SHALL NOT be counted.
REQ-033 Outputs by state:
- busy=1 in CLEAR, SYNC and MEASURE.
- done=1 only in DONE.
- fail=1 only in FAIL.
- gen_en=0 in IDLE, DONE and FAIL.
REQ-034 abort in CLEAR, SYNC or MEASURE SHALL cause →IDLE on the next edge, with word_count and err_total holding their values.
REQ-035 abort SHALL take priority over start, lock, timeout and window completion in the same cycle.
REQ-036 word_count and err_total SHALL hold their values in DONE, FAIL and IDLE until the next accepted start.

Reset
REQ-037 reset=0 SHALL immediately force the following, with no clock required:
- state=IDLE.
- sel=0, gen_en=0, chk_clr=0, busy=0, done=0, fail=0.
- word_count=0, err_total=0.
- configuration registers and the timeout counter = 0.
REQ-038 Reset asserted mid-run SHALL abandon the run, and no done or fail SHALL be produced.
REQ-039 After reset is released, the block SHALL stay in IDLE until start.

Verification
REQ-040 Nominal run: win_len=4, sync_to=10, lock high from the 2nd SYNC cycle, err_word = 0x00, 0x01, 0xFF, 0x03 each with err_valid.
- Required: CLEAR for 1 cycle, DONE with word_count=4 and err_total=11, done=1, busy=0.
REQ-041 Sync timeout: sync_to=5 and lock held at 0.
- Required: fail=1 after 5 SYNC cycles, word_count=0.
REQ-042 Lock loss: win_len=100, lock drops after 10 valid words with err_word=0x80.
- Required: FAIL with word_count=10 and err_total=10.
REQ-043 Abort priority: start and abort asserted together in IDLE → remains IDLE.
- Abort in MEASURE after 3 words → IDLE with word_count=3 retained.
- A new start → word_count=0 in CLEAR.
REQ-044 Saturation: with CNT_W=8, 40 valid words of err_word=0xFF.
- Required: err_total=255, held, with no wrap.
REQ-045 Async reset mid-MEASURE: reset low between clock edges.
- Required: all outputs 0 and state=0 before the next edge.
- start ignored while reset=0.
